// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the store formatter and data memory,
// draining over req/gnt and flagging loads that overlap a resident store.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_wdata,
    input  logic [3:0]       st_be,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic [3:0]       ld_be,
    output logic             ld_hazard,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    output logic [PTR_W:0]   sb_count,
    output logic             sb_empty
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
    logic [PTR_W:0]   count_q, count_d;
    logic             enq, deq, hit;

    // A zero-enable store completes its handshake but never occupies an entry.
    assign st_ready  = count_q != FULL;
    assign enq       = st_valid && st_ready && (st_be != 4'b0000);
    assign mem_req   = count_q != '0;
    assign deq       = mem_req && mem_gnt;
    assign mem_addr  = {addr_q[rd_ptr_q], 2'b00};
    assign mem_wdata = data_q[rd_ptr_q];
    assign mem_be    = be_q[rd_ptr_q];
    assign sb_count  = count_q;
    assign sb_empty  = count_q == '0;
    assign ld_hazard = ld_valid && hit;

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = (enq && !deq) ? count_q + (PTR_W+1)'(1) :
                   (deq && !enq) ? count_q - (PTR_W+1)'(1) : count_q;
    end

    // Resident entries are those within count_q slots of the read pointer.
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            hit = hit | (({1'b0, off} < count_q) && (addr_q[i] == ld_addr[31:2]) &&
                         ((be_q[i] & ld_be) != 4'b0000));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq) begin
                addr_q[wr_ptr_q] <= st_addr[31:2];
                data_q[wr_ptr_q] <= st_wdata;
                be_q[wr_ptr_q]   <= st_be;
            end
        end
    end
endmodule
